// File: rtl/clocking_pkg.sv
// Shared clocking types: phase state encoding, wait counter width, cycle counter width.
package clocking_pkg;

    localparam int unsigned PHASES_PER_CYCLE = 4;
    localparam int unsigned STATE_W          = 3;
    localparam int unsigned WAIT_W           = 3;
    localparam int unsigned CYCLE_CNT_W      = 8;

    typedef logic [STATE_W-1:0] phase_state_t;
    typedef logic [WAIT_W-1:0]  wait_cnt_t;

    localparam phase_state_t S_HOLD = 3'd0;
    localparam phase_state_t PH1_A  = 3'd1;
    localparam phase_state_t PH1_B  = 3'd2;
    localparam phase_state_t PH2_A  = 3'd3;
    localparam phase_state_t PH2_W  = 3'd4;
    localparam phase_state_t PH2_B  = 3'd5;

endpackage

// File: rtl/reset_gate.sv
// Saturating completed-bus-cycle counter gating CPU reset release and the clock_running flag.
module reset_gate
    import clocking_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned RUN_CYCLES   = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic locked,
    input  logic cpu_ce,
    output logic cpu_reset,
    output logic clock_running
);

    localparam logic [CYCLE_CNT_W-1:0] CNT_MAX = {CYCLE_CNT_W{1'b1}};

    logic [CYCLE_CNT_W-1:0] r_cnt;
    logic [CYCLE_CNT_W-1:0] w_cnt_nxt;
    logic                   r_cpu_reset;
    logic                   r_clock_running;

    // Lock loss restarts the stability count from zero.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (!locked) begin
            w_cnt_nxt = '0;
        end else if (cpu_ce && (r_cnt != CNT_MAX)) begin
            w_cnt_nxt = r_cnt + CYCLE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt           <= '0;
            r_cpu_reset     <= 1'b1;
            r_clock_running <= 1'b0;
        end else begin
            r_cnt           <= w_cnt_nxt;
            r_cpu_reset     <= (w_cnt_nxt < CYCLE_CNT_W'(RESET_CYCLES));
            r_clock_running <= (w_cnt_nxt >= CYCLE_CNT_W'(RUN_CYCLES));
        end
    end

    assign cpu_reset     = r_cpu_reset;
    assign clock_running = r_clock_running;

endmodule

// File: rtl/phase_sequencer.sv
// 65c02 bus-cycle sequencer on the 4x-phi2 clock: phi1/phi2 phases, strobes,
// phi2-high stretching for slow devices and wait requests, and CPU reset gating.
module phase_sequencer
    import clocking_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 8,
    parameter int unsigned RUN_CYCLES   = 3,
    parameter int unsigned SLOW_WAIT    = 2,
    parameter int unsigned MAX_WAIT     = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic locked,
    input  logic slow_sel,
    input  logic wait_req,
    output logic phi2,
    output logic phi1,
    output logic addr_stb,
    output logic cpu_ce,
    output logic cpu_reset,
    output logic clock_running,
    output logic wait_timeout
);

    phase_state_t r_state;
    phase_state_t w_state_nxt;
    wait_cnt_t    r_wait_cnt;
    wait_cnt_t    w_wait_cnt_nxt;
    wait_cnt_t    r_wait_tgt;
    wait_cnt_t    w_wait_tgt_nxt;
    wait_cnt_t    w_wait_inc;
    logic         r_timeout;
    logic         w_timeout_nxt;
    logic         r_phi2;
    logic         r_phi1;
    logic         r_addr_stb;
    logic         r_cpu_ce;

    // Wait slots completed including the current PH2_W slot.
    assign w_wait_inc = r_wait_cnt + WAIT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_wait_tgt_nxt = r_wait_tgt;
        w_timeout_nxt  = r_timeout;
        case (r_state)
            S_HOLD: begin
                if (locked) begin
                    w_state_nxt = PH1_A;
                end
            end
            PH1_A: begin
                w_state_nxt = PH1_B;
            end
            PH1_B: begin
                w_state_nxt    = PH2_A;
                w_wait_tgt_nxt = slow_sel ? WAIT_W'(SLOW_WAIT) : '0;
                w_wait_cnt_nxt = '0;
            end
            PH2_A: begin
                if ((r_wait_tgt != '0) || wait_req) begin
                    w_state_nxt = PH2_W;
                end else begin
                    w_state_nxt = PH2_B;
                end
            end
            PH2_W: begin
                w_wait_cnt_nxt = w_wait_inc;
                if ((w_wait_inc >= r_wait_tgt) && !wait_req) begin
                    w_state_nxt = PH2_B;
                end else if (w_wait_inc == WAIT_W'(MAX_WAIT)) begin
                    w_state_nxt   = PH2_B;
                    w_timeout_nxt = 1'b1;
                end
            end
            PH2_B: begin
                w_state_nxt = PH1_A;
            end
            default: begin
                w_state_nxt = S_HOLD;
            end
        endcase
        // Lock loss aborts the cycle without a cpu_ce; a pending timeout is not recorded.
        if (!locked) begin
            w_state_nxt    = S_HOLD;
            w_wait_cnt_nxt = '0;
            w_timeout_nxt  = r_timeout;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_HOLD;
            r_wait_cnt <= '0;
            r_wait_tgt <= '0;
            r_timeout  <= 1'b0;
            r_phi2     <= 1'b0;
            r_phi1     <= 1'b1;
            r_addr_stb <= 1'b0;
            r_cpu_ce   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_wait_tgt <= w_wait_tgt_nxt;
            r_timeout  <= w_timeout_nxt;
            r_phi2     <= (w_state_nxt == PH2_A) || (w_state_nxt == PH2_W) || (w_state_nxt == PH2_B);
            r_phi1     <= !((w_state_nxt == PH2_A) || (w_state_nxt == PH2_W) || (w_state_nxt == PH2_B));
            r_addr_stb <= (w_state_nxt == PH1_B);
            r_cpu_ce   <= (w_state_nxt == PH2_B);
        end
    end

    reset_gate #(
        .RESET_CYCLES (RESET_CYCLES),
        .RUN_CYCLES   (RUN_CYCLES)
    ) u_reset_gate (
        .clk           (clk),
        .reset         (reset),
        .locked        (locked),
        .cpu_ce        (r_cpu_ce),
        .cpu_reset     (cpu_reset),
        .clock_running (clock_running)
    );

    assign phi2         = r_phi2;
    assign phi1         = r_phi1;
    assign addr_stb     = r_addr_stb;
    assign cpu_ce       = r_cpu_ce;
    assign wait_timeout = r_timeout;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: slot-position model of the bus cycle checked every clock,
// plus directed scenarios with hand-computed cycle lengths and flag values.
module tb_phase_sequencer;

    localparam int RESET_CYCLES = 8;
    localparam int RUN_CYCLES   = 3;
    localparam int SLOW_WAIT    = 2;
    localparam int MAX_WAIT     = 7;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic locked   = 1'b0;
    logic slow_sel = 1'b0;
    logic wait_req = 1'b0;
    logic phi2, phi1, addr_stb, cpu_ce, cpu_reset, clock_running, wait_timeout;

    int checks = 0;
    int errors = 0;

    // Model: position within the bus cycle (0 = first phi1 slot), whether the current
    // slot is the last phi2-high slot, completed-cycle count and sticky timeout.
    bit m_valid = 1'b0;
    bit m_hold  = 1'b1;
    bit m_final = 1'b0;
    bit m_to    = 1'b0;
    int m_pos   = 0;
    int m_tgt   = 0;
    int m_cnt   = 0;

    int hi_run = 0, cyc_run = 0, last_high = 0, last_cyc = 0;

    phase_sequencer #(
        .RESET_CYCLES (RESET_CYCLES),
        .RUN_CYCLES   (RUN_CYCLES),
        .SLOW_WAIT    (SLOW_WAIT),
        .MAX_WAIT     (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .locked        (locked),
        .slow_sel      (slow_sel),
        .wait_req      (wait_req),
        .phi2          (phi2),
        .phi1          (phi1),
        .addr_stb      (addr_stb),
        .cpu_ce        (cpu_ce),
        .cpu_reset     (cpu_reset),
        .clock_running (clock_running),
        .wait_timeout  (wait_timeout)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on every active edge, from the inputs the DUT samples there.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            m_valid = 1'b1; m_hold = 1'b1; m_pos = 0; m_final = 1'b0;
            m_cnt = 0; m_to = 1'b0; m_tgt = 0;
        end else if (m_valid) begin
            if (!locked) begin
                m_hold = 1'b1; m_pos = 0; m_final = 1'b0; m_cnt = 0;
            end else if (m_hold) begin
                m_hold = 1'b0; m_pos = 0; m_final = 1'b0;
            end else if (m_final) begin
                if (m_cnt < 255) m_cnt = m_cnt + 1;
                m_pos = 0; m_final = 1'b0;
            end else begin
                if (m_pos == 1) m_tgt = slow_sel ? SLOW_WAIT : 0;
                if (m_pos >= 2) begin
                    if ((m_pos - 2) >= m_tgt && !wait_req) begin
                        m_final = 1'b1;
                    end else if ((m_pos - 2) == MAX_WAIT) begin
                        m_final = 1'b1;
                        m_to    = 1'b1;
                    end
                end
                m_pos = m_pos + 1;
            end
        end
    end

    // Per-cycle comparison against the model, then phase-length bookkeeping.
    initial forever begin
        @(negedge clk);
        if (m_valid) begin
            cmp("phi2",          phi2,          !m_hold && m_pos >= 2);
            cmp("phi1",          phi1,          !(!m_hold && m_pos >= 2));
            cmp("addr_stb",      addr_stb,      !m_hold && m_pos == 1);
            cmp("cpu_ce",        cpu_ce,        !m_hold && m_final);
            cmp("cpu_reset",     cpu_reset,     m_cnt < RESET_CYCLES);
            cmp("clock_running", clock_running, m_cnt >= RUN_CYCLES);
            cmp("wait_timeout",  wait_timeout,  m_to);
            hi_run  = phi2 ? hi_run + 1 : 0;
            cyc_run = cyc_run + 1;
            if (cpu_ce) begin
                last_high = hi_run;
                last_cyc  = cyc_run;
                cyc_run   = 0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ce(input int budget);
        int n;
        n = 0;
        tick();
        while (!cpu_ce && n < budget) begin
            tick();
            n++;
        end
        if (!cpu_ce) begin
            checks++;
            errors++;
            $display("FAIL wait_ce: no cpu_ce within %0d clks, expected a pulse", budget);
        end
    endtask

    // Eight cycles after lock: running after the 3rd cpu_ce, reset release after the 8th.
    task automatic release_seq();
        for (int i = 1; i <= RESET_CYCLES; i++) begin
            wait_ce(20);
            if (i > 1) begin
                chk_int("nom_cycle_len", last_cyc, 4);
                chk_int("nom_high_len", last_high, 2);
            end
            tick();
            cmp("run_after_ce", clock_running, i >= 3);
            cmp("rst_after_ce", cpu_reset, i < 8);
        end
    endtask

    task automatic chk_reset_vals();
        cmp("rst_phi2", phi2, 1'b0);
        cmp("rst_phi1", phi1, 1'b1);
        cmp("rst_addr_stb", addr_stb, 1'b0);
        cmp("rst_cpu_ce", cpu_ce, 1'b0);
        cmp("rst_cpu_reset", cpu_reset, 1'b1);
        cmp("rst_running", clock_running, 1'b0);
        cmp("rst_timeout", wait_timeout, 1'b0);
    endtask

    initial begin
        reset = 1'b1; locked = 1'b1;
        tick(); tick();
        chk_reset_vals();
        reset = 1'b0;

        release_seq();

        // Slow device: two wait slots.
        slow_sel = 1'b1;
        wait_ce(20);
        slow_sel = 1'b0;
        chk_int("slow_high_len", last_high, 4);
        chk_int("slow_cycle_len", last_cyc, 6);
        wait_ce(20);
        chk_int("post_slow_cycle_len", last_cyc, 4);
        chk_int("post_slow_high_len", last_high, 2);

        // wait_req high for PH2_A and two wait slots, low on the third.
        tick(); tick();
        wait_req = 1'b1;
        tick(); tick(); tick(); tick();
        wait_req = 1'b0;
        wait_ce(20);
        chk_int("req_high_len", last_high, 5);
        chk_int("req_cycle_len", last_cyc, 7);
        cmp("req_no_timeout", wait_timeout, 1'b0);

        // Stuck wait_req: forced exit after MAX_WAIT slots.
        wait_req = 1'b1;
        wait_ce(30);
        wait_req = 1'b0;
        chk_int("stuck_high_len", last_high, 9);
        chk_int("stuck_cycle_len", last_cyc, 11);
        cmp("stuck_timeout", wait_timeout, 1'b1);
        wait_ce(20);
        chk_int("after_stuck_cycle_len", last_cyc, 4);
        cmp("timeout_sticky", wait_timeout, 1'b1);

        // Lock loss during PH2_W.
        cmp("pre_lockloss_cpu_reset", cpu_reset, 1'b0);
        tick(); tick();
        wait_req = 1'b1;
        tick(); tick();
        cmp("in_wait_phi2", phi2, 1'b1);
        locked = 1'b0;
        tick();
        cmp("ll_phi2", phi2, 1'b0);
        cmp("ll_cpu_ce", cpu_ce, 1'b0);
        cmp("ll_cpu_reset", cpu_reset, 1'b1);
        cmp("ll_running", clock_running, 1'b0);
        cmp("ll_timeout_kept", wait_timeout, 1'b1);
        wait_req = 1'b0;
        tick(); tick();
        locked = 1'b1;
        release_seq();

        // Reset asserted during PH2_A with the timeout flag set.
        tick(); tick();
        cmp("pre_reset_phi2", phi2, 1'b1);
        cmp("pre_reset_timeout", wait_timeout, 1'b1);
        reset = 1'b1;
        tick();
        chk_reset_vals();
        reset = 1'b0;
        wait_ce(20);
        wait_ce(20);
        chk_int("post_reset_cycle_len", last_cyc, 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
